// File: rtl/host_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : host_cmd_pkg
// Description : Shared constants, frame checksum helper and FSM state type
//               for the host command decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package host_cmd_pkg;

    localparam logic [7:0] HDR    = 8'hA5;
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    localparam int TIMEOUT_CYC = 10000;
    localparam int CNT_W       = 14;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_CMD  = 3'd1,
        GET_DATA = 3'd2,
        GET_CHK  = 3'd3,
        RESP     = 3'd4
    } state_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] data);
        return HDR ^ cmd ^ data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/host_cmd_decoder_byte_timeout.sv
`default_nettype none
// ============================================================================
// Module      : byte_timeout
// Description : Inter-byte timeout counter; expired is high during the
//               TIMEOUT_CYC-th consecutive running cycle without a reload.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_timeout
    import host_cmd_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic reload,
    output logic expired
);

    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    assign expired = run && (r_cnt_q == C_LAST_CNT);

    always_comb begin
        w_cnt_d = r_cnt_q + CNT_W'(1);
        // Expiry also clears: the owner leaves the running states on that edge.
        if (!run || reload || expired) begin
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/host_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : host_cmd_decoder
// Description : Decodes A5/CMD/DATA/CHK host frames into toilet-core control
//               bits and status readback, answering with ACK, NAK or status.
// Revision    : 1.0 - initial release
// ============================================================================
module host_cmd_decoder
    import host_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       stt_ready,
    input  logic       stt_using,
    input  logic       stt_spraying,
    input  logic       stt_drying,
    input  logic       stt_discharge,
    input  logic       count_spray_done,
    input  logic       count_drying_done,
    input  logic       count_dis_done,
    output logic       reg_user_en,
    output logic       reg_toilet_using,
    output logic       reg_spray_en,
    output logic       reg_sp_dr_auto_en,
    output logic       reg_spray_mode,
    output logic       reg_auto_dis_en,
    output logic       reg_de_ur,
    output logic       warm_en,
    output logic       frame_err
);

    state_t     r_state_q,     w_state_d;
    logic [7:0] r_cmd_q,       w_cmd_d;
    logic [7:0] r_data_q,      w_data_d;
    logic [7:0] r_ctrl_q,      w_ctrl_d;
    logic [7:0] r_tx_data_q,   w_tx_data_d;
    logic       r_tx_valid_q,  w_tx_valid_d;
    logic       r_frame_err_q, w_frame_err_d;

    logic       w_run;
    logic       w_reload;
    logic       w_expired;
    logic       w_timeout;
    logic       w_chk_ok;
    logic [7:0] w_status;

    assign w_run     = (r_state_q == GET_CMD) || (r_state_q == GET_DATA) || (r_state_q == GET_CHK);
    assign w_reload  = w_run && rx_valid;
    // A byte arriving on the expiry cycle takes priority over the abort.
    assign w_timeout = w_expired && !rx_valid;
    assign w_chk_ok  = (rx_data == frame_chk(r_cmd_q, r_data_q));
    assign w_status  = {stt_ready, stt_using, stt_spraying, stt_drying,
                        stt_discharge, count_spray_done, count_drying_done, count_dis_done};

    byte_timeout u_byte_timeout (
        .clk     (clk),
        .reset   (reset),
        .run     (w_run),
        .reload  (w_reload),
        .expired (w_expired)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_cmd_d       = r_cmd_q;
        w_data_d      = r_data_q;
        w_ctrl_d      = r_ctrl_q;
        w_ctrl_d[6]   = 1'b0;
        w_tx_valid_d  = r_tx_valid_q;
        w_tx_data_d   = r_tx_data_q;
        w_frame_err_d = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (rx_valid && (rx_data == HDR)) begin
                    w_state_d = GET_CMD;
                end
            end
            GET_CMD: begin
                if (rx_valid) begin
                    w_cmd_d   = rx_data;
                    w_state_d = GET_DATA;
                end else if (w_timeout) begin
                    w_state_d     = IDLE;
                    w_frame_err_d = 1'b1;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    w_data_d  = rx_data;
                    w_state_d = GET_CHK;
                end else if (w_timeout) begin
                    w_state_d     = IDLE;
                    w_frame_err_d = 1'b1;
                end
            end
            GET_CHK: begin
                if (rx_valid) begin
                    w_state_d    = RESP;
                    w_tx_valid_d = 1'b1;
                    w_tx_data_d  = NAK;
                    if (w_chk_ok && (r_cmd_q == CMD_WR)) begin
                        w_ctrl_d    = r_data_q;
                        w_tx_data_d = ACK;
                    end else if (w_chk_ok && (r_cmd_q == CMD_RD)) begin
                        w_tx_data_d = w_status;
                    end
                end else if (w_timeout) begin
                    w_state_d     = IDLE;
                    w_frame_err_d = 1'b1;
                end
            end
            RESP: begin
                if (tx_ready) begin
                    w_state_d    = IDLE;
                    w_tx_valid_d = 1'b0;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= IDLE;
            r_cmd_q       <= '0;
            r_data_q      <= '0;
            r_ctrl_q      <= '0;
            r_tx_data_q   <= '0;
            r_tx_valid_q  <= 1'b0;
            r_frame_err_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cmd_q       <= w_cmd_d;
            r_data_q      <= w_data_d;
            r_ctrl_q      <= w_ctrl_d;
            r_tx_data_q   <= w_tx_data_d;
            r_tx_valid_q  <= w_tx_valid_d;
            r_frame_err_q <= w_frame_err_d;
        end
    end

    assign tx_valid          = r_tx_valid_q;
    assign tx_data           = r_tx_data_q;
    assign frame_err         = r_frame_err_q;
    assign reg_user_en       = r_ctrl_q[0];
    assign reg_toilet_using  = r_ctrl_q[1];
    assign reg_spray_en      = r_ctrl_q[2];
    assign reg_sp_dr_auto_en = r_ctrl_q[3];
    assign reg_spray_mode    = r_ctrl_q[4];
    assign reg_auto_dis_en   = r_ctrl_q[5];
    assign reg_de_ur         = r_ctrl_q[6];
    assign warm_en           = r_ctrl_q[7];

endmodule
`default_nettype wire
